// File: rtl/tc_pkg.sv
// Shared definitions for timer_counter: FSM state codes, register word offsets,
// CTRL field positions and MODE encodings.
package tc_pkg;

    typedef logic [1:0] tc_state_t;

    localparam tc_state_t ST_IDLE = 2'd0;
    localparam tc_state_t ST_LOAD = 2'd1;
    localparam tc_state_t ST_CNT  = 2'd2;
    localparam tc_state_t ST_INT  = 2'd3;

    // Word offsets, i.e. addr[3:2] within the 16-byte window
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // Encodings 2 and 3 fall back to one-shot behaviour.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/tc_byte_merge.sv
// Byte-lane merge of a register write. Define TC_BYTE_WRITE_EN for per-lane
// updates; otherwise any nonzero byteen replaces the whole word.
module tc_byte_merge (
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_byteen,
    output logic [31:0] o_word
);

`ifdef TC_BYTE_WRITE_EN
    always_comb begin
        o_word = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_byteen[b]) begin
                o_word[8*b +: 8] = i_wdata[8*b +: 8];
            end
        end
    end
`else
    assign o_word = (|i_byteen) ? i_wdata : i_old;
`endif

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt. Byte-lane writes are enabled by defining TC_BYTE_WRITE_EN.
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_t          r_state;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [31:0]        r_preset;
    logic [31:0]        r_count;
    logic               r_flag;

    logic               w_sel;
    logic [1:0]         w_off;
    logic               w_wr_ctrl;
    logic               w_wr_preset;
    logic [31:0]        w_old;
    logic [31:0]        w_merged;
    logic               w_unused;

    assign w_sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off       = addr[3:2];
    assign w_wr_ctrl   = w_sel && (|byteen) && (w_off == OFF_CTRL);
    assign w_wr_preset = w_sel && (|byteen) && (w_off == OFF_PRESET);
    assign w_old       = (w_off == OFF_CTRL) ? {{(32-CTRL_W){1'b0}}, r_ctrl} : r_preset;
    assign w_unused    = &{1'b0, addr[1:0]};

    tc_byte_merge u_merge (
        .i_old    (w_old),
        .i_wdata  (wdata),
        .i_byteen (byteen),
        .o_word   (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_flag   <= 1'b0;
        end else begin
            if (w_wr_preset) begin
                r_preset <= w_merged;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_ctrl[CTRL_EN]) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!r_ctrl[CTRL_EN]) begin
                        r_state <= ST_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count <= '0;
                        // A CTRL write on the terminal edge suppresses the interrupt
                        // and restarts from IDLE so a fresh run keeps normal timing.
                        if (w_wr_ctrl) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_flag  <= 1'b1;
                            r_state <= ST_INT;
                        end
                    end
                end
                ST_INT: begin
                    if (is_reload(r_ctrl[CTRL_MODE_LSB +: 2])) begin
                        r_flag  <= 1'b0;
                        r_state <= ST_LOAD;
                    end else begin
                        r_ctrl[CTRL_EN] <= 1'b0;
                        r_state         <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Placed last so a CTRL write overrides the FSM's flag and EN updates.
            if (w_wr_ctrl) begin
                r_ctrl <= w_merged[CTRL_W-1:0];
                r_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (w_sel) begin
            case (w_off)
                OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
                OFF_PRESET: rdata = r_preset;
                OFF_COUNT:  rdata = r_count;
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = r_flag & r_ctrl[CTRL_IM];

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7F00, 16-byte-aligned base of the register window.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addr  input  32  byte address from the CPU data bus.
REQ-005 SHALL have port byteen  input  4  per-byte write enables; all-zero means no write.
REQ-006 SHALL have port wdata  input  32  write data, byte lanes aligned to byteen.
REQ-007 SHALL have port rdata  output  32  combinational read data for addr.
REQ-008 SHALL have port irq  output  1  interrupt request to the CPU.

Function
REQ-009 SHALL select itself when addr[31:4]==BASE_ADDR[31:4]; unselected writes are ignored and rdata is 0.
REQ-010 SHALL map registers: offset 0x0 CTRL, 0x4 PRESET, 0x8 COUNT (read-only), 0xC reads 0 and ignores writes.
REQ-011 SHALL define CTRL fields: bit0 EN, bits2:1 MODE (0 one-shot, 1 auto-reload, 2/3 behave as 0), bit3 IM; bits31:4 read 0.
REQ-012 SHALL implement states IDLE, LOAD, CNT, INT.
REQ-013 IDLE: EN=1 -> LOAD; else stay.
REQ-014 LOAD: COUNT<=PRESET; -> CNT.
REQ-015 CNT: EN=0 -> IDLE with COUNT held; else COUNT>1 -> COUNT-1, stay; else COUNT<=0, set irq flag, -> INT.
REQ-016 INT: MODE one-shot -> clear EN, -> IDLE, flag held; MODE auto-reload -> clear flag, -> LOAD.
REQ-017 SHALL drive irq = flag AND IM.
REQ-018 SHALL raise irq exactly PRESET+2 cycles after the edge that writes EN=1 from IDLE, for PRESET>=1; PRESET=0 behaves as PRESET=1.
REQ-019 Any CTRL write SHALL clear the flag; a CTRL write takes priority over a flag set and over the EN clear of REQ-016 in the same cycle.
REQ-020 PRESET writes during CNT SHALL NOT affect COUNT until the next LOAD.
REQ-021 Auto-reload SHALL produce a one-cycle irq pulse every PRESET+2 cycles while EN=1.
REQ-022 Writes to COUNT and to unmapped offsets SHALL have no effect.

Reset
REQ-023 On reset SHALL asynchronously set state IDLE, and clear CTRL, PRESET, COUNT and the flag; irq=0 and rdata reflects zeroed registers.
REQ-024 Reset asserted mid-count SHALL abort the count; irq SHALL deassert immediately.

Configuration
REQ-025 With TC_BYTE_WRITE_EN defined, SHALL update only the byte lanes whose byteen bit is set.
REQ-026 Without TC_BYTE_WRITE_EN, any nonzero byteen SHALL write the full 32-bit word.

Structure
REQ-027 tc_pkg SHALL hold the state enum, register offsets, CTRL bit positions and MODE encodings.
REQ-028 Byte-lane merging SHALL live in one sub-module tc_byte_merge (old word, wdata, byteen -> new word).

Verification
REQ-029 PRESET=5, CTRL<=0x9 -> irq rises 7 cycles later; COUNT reads 0; CTRL reads 0x8 one cycle after; irq holds until a CTRL write.
REQ-030 PRESET=3, CTRL<=0xB -> irq is a 1-cycle pulse every 5 cycles; COUNT cycles 3,2,1,0.
REQ-031 Counting with PRESET=100, CTRL<=0x0 at COUNT=40 -> COUNT holds 40 and irq stays 0; CTRL<=0x1 -> reload to 100.
REQ-032 byteen=4'b0001, wdata=0xAABBCCDD to PRESET=0x11223344 -> 0x112233DD with macro, 0xAABBCCDD without.
REQ-033 Reset pulse at COUNT=2 in CNT -> irq=0, all registers read 0, state IDLE.
REQ-034 Flag set and CTRL<=0x9 written in the same cycle -> flag clear, EN=1, new count begins.
